// File: rtl/election_pkg.sv
// rtl/election_pkg.sv - shared types and sizing helpers for the ballot session
package election_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_TALLY   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEFAULT_N_VOTERS = 7;

    function automatic int cnt_width(input int n_voters);
        return $clog2(n_voters + 1);
    endfunction

endpackage

// File: rtl/election_session_if.sv
// rtl/election_session_if.sv - control, ballot and result signals of one ballot session
interface election_session_if
    import election_pkg::*;
#(
    parameter int N_VOTERS = DEFAULT_N_VOTERS,
    parameter int CNT_W    = cnt_width(N_VOTERS)
);
    logic                i_start;
    logic [CNT_W-1:0]    i_threshold;
    logic [CNT_W-1:0]    i_quorum;
    logic                i_ballot_valid;
    logic [N_VOTERS-1:0] i_ballot_mask;
    logic [N_VOTERS-1:0] i_ballot_vote;
    logic                i_close;
    logic                o_busy;
    logic                o_result_valid;
    logic                o_result;
    logic [CNT_W-1:0]    o_yes_count;
    logic [CNT_W-1:0]    o_turnout;

    modport master (
        output i_start, i_threshold, i_quorum, i_ballot_valid,
               i_ballot_mask, i_ballot_vote, i_close,
        input  o_busy, o_result_valid, o_result, o_yes_count, o_turnout
    );

    modport slave (
        input  i_start, i_threshold, i_quorum, i_ballot_valid,
               i_ballot_mask, i_ballot_vote, i_close,
        output o_busy, o_result_valid, o_result, o_yes_count, o_turnout
    );
endinterface

// File: rtl/election_ballot_box.sv
// rtl/election_ballot_box.sv - per-voter voted/vote registers, first vote wins
module election_ballot_box #(
    parameter int N_VOTERS = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_wr_en,
    input  logic [N_VOTERS-1:0] i_mask,
    input  logic [N_VOTERS-1:0] i_vote,
    output logic [N_VOTERS-1:0] o_voted,
    output logic [N_VOTERS-1:0] o_votes,
    output logic                o_all_voted
);
    logic [N_VOTERS-1:0] r_voted;
    logic [N_VOTERS-1:0] r_votes;
    logic [N_VOTERS-1:0] w_fresh;
    logic [N_VOTERS-1:0] w_voted_next;

    // Only voters that have not voted yet may write; later ballots are dropped.
    assign w_fresh      = i_wr_en ? (i_mask & ~r_voted) : '0;
    assign w_voted_next = r_voted | w_fresh;
    // Includes this cycle's ballot so full turnout closes on the same edge.
    assign o_all_voted  = &w_voted_next;
    assign o_voted      = r_voted;
    assign o_votes      = r_votes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_voted <= '0;
            r_votes <= '0;
        end else if (i_clear) begin
            r_voted <= '0;
            r_votes <= '0;
        end else begin
            r_voted <= w_voted_next;
            r_votes <= (r_votes & ~w_fresh) | (i_vote & w_fresh);
        end
    end
endmodule

// File: rtl/election_session.sv
// rtl/election_session.sv - ballot session FSM: collect, serial tally, held result
module election_session
    import election_pkg::*;
#(
    parameter int N_VOTERS = DEFAULT_N_VOTERS,
    parameter int CNT_W    = cnt_width(N_VOTERS),
    parameter int TIMEOUT  = 0,
    parameter int TO_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    election_session_if.slave   bus
);
    localparam int IDX_W = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_VOTERS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_threshold;
    logic [CNT_W-1:0]    r_quorum;
    logic [CNT_W-1:0]    r_yes;
    logic [CNT_W-1:0]    r_turnout;
    logic                r_result;
    logic [IDX_W-1:0]    r_idx;
    logic [TO_W-1:0]     r_timer;

    logic                w_start_ok;
    logic                w_timeout;
    logic                w_wr_en;
    logic                w_all_voted;
    logic [N_VOTERS-1:0] w_voted;
    logic [N_VOTERS-1:0] w_votes;
    logic                w_cur_voted;
    logic                w_cur_yes;
    logic [CNT_W-1:0]    w_yes_next;
    logic [CNT_W-1:0]    w_turnout_next;

    assign w_start_ok = bus.i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_timeout  = (TIMEOUT != 0) && (r_timer == TO_LAST);
    assign w_wr_en    = (r_state == ST_COLLECT) && bus.i_ballot_valid;

    election_ballot_box #(
        .N_VOTERS (N_VOTERS)
    ) u_box (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_ok),
        .i_wr_en     (w_wr_en),
        .i_mask      (bus.i_ballot_mask),
        .i_vote      (bus.i_ballot_vote),
        .o_voted     (w_voted),
        .o_votes     (w_votes),
        .o_all_voted (w_all_voted)
    );

    assign w_cur_voted    = w_voted[r_idx];
    assign w_cur_yes      = w_voted[r_idx] & w_votes[r_idx];
    assign w_turnout_next = r_turnout + CNT_W'(w_cur_voted);
    assign w_yes_next     = r_yes + CNT_W'(w_cur_yes);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) w_next_state = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (bus.i_close || w_timeout || w_all_voted) w_next_state = ST_TALLY;
            end
            ST_TALLY: begin
                if (r_idx == IDX_LAST) w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_threshold <= '0;
            r_quorum    <= '0;
            r_yes       <= '0;
            r_turnout   <= '0;
            r_result    <= 1'b0;
            r_idx       <= '0;
            r_timer     <= '0;
        end else if (w_start_ok) begin
            r_threshold <= bus.i_threshold;
            r_quorum    <= bus.i_quorum;
            r_yes       <= '0;
            r_turnout   <= '0;
            r_result    <= 1'b0;
            r_idx       <= '0;
            r_timer     <= '0;
        end else if (r_state == ST_COLLECT) begin
            r_timer <= r_timer + 1'b1;
            r_idx   <= '0;
        end else if (r_state == ST_TALLY) begin
            r_yes     <= w_yes_next;
            r_turnout <= w_turnout_next;
            r_idx     <= r_idx + 1'b1;
            // Decide on the last tally edge so result is registered with DONE.
            if (r_idx == IDX_LAST) begin
                r_result <= (w_yes_next >= r_threshold) && (w_turnout_next >= r_quorum);
            end
        end
    end

    assign bus.o_busy         = (r_state == ST_COLLECT) || (r_state == ST_TALLY);
    assign bus.o_result_valid = (r_state == ST_DONE);
    assign bus.o_result       = r_result;
    assign bus.o_yes_count    = r_yes;
    assign bus.o_turnout      = r_turnout;
endmodule

// File: tb/tb_election_session.sv
// tb/tb_election_session.sv - scoreboard bench for election_session, 7 voters, timeout 16
module tb_election_session;
    import election_pkg::*;

    typedef struct packed {
        logic [2:0] yes;
        logic [2:0] turn;
        logic       res;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb[$];
    logic [6:0] m_voted;
    logic [6:0] m_votes;

    election_session_if #(.N_VOTERS(7)) bus ();

    election_session #(
        .N_VOTERS (7),
        .TIMEOUT  (16),
        .TO_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] thr, input logic [2:0] q);
        bus.i_start     = 1'b1;
        bus.i_threshold = thr;
        bus.i_quorum    = q;
        m_voted = '0;
        m_votes = '0;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic m_ballot(input logic [6:0] mask, input logic [6:0] vote);
        logic [6:0] fresh;
        fresh   = mask & ~m_voted;
        m_votes = (m_votes & ~fresh) | (vote & fresh);
        m_voted = m_voted | mask;
    endtask

    task automatic m_expect(input logic [2:0] thr, input logic [2:0] q);
        res_t e;
        e.yes  = 3'($countones(m_voted & m_votes));
        e.turn = 3'($countones(m_voted));
        e.res  = (e.yes >= thr) && (e.turn >= q);
        sb.push_back(e);
    endtask

    task automatic ballot(input logic [6:0] mask, input logic [6:0] vote, input logic cls);
        bus.i_ballot_valid = 1'b1;
        bus.i_ballot_mask  = mask;
        bus.i_ballot_vote  = vote;
        bus.i_close        = cls;
        m_ballot(mask, vote);
        step();
        bus.i_ballot_valid = 1'b0;
        bus.i_ballot_mask  = '0;
        bus.i_ballot_vote  = '0;
        bus.i_close        = 1'b0;
    endtask

    task automatic do_close();
        bus.i_close = 1'b1;
        step();
        bus.i_close = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.o_result_valid && cyc < 64) begin
            step();
            cyc++;
        end
    endtask

    function automatic res_t get_obs();
        res_t o;
        o.yes  = bus.o_yes_count;
        o.turn = bus.o_turnout;
        o.res  = bus.o_result;
        return o;
    endfunction

    task automatic test_reset();
        logic [9:0] o;
        rst = 1'b1;
        #1;
        o = {bus.o_busy, bus.o_result_valid, bus.o_result, bus.o_yes_count, bus.o_turnout};
        n_tests++;
        if (o !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0", o);
        end
        step();
        rst = 1'b0;
        bus.i_ballot_valid = 1'b1;
        bus.i_ballot_mask  = '1;
        bus.i_close        = 1'b1;
        step();
        step();
        bus.i_ballot_valid = 1'b0;
        bus.i_ballot_mask  = '0;
        bus.i_close        = 1'b0;
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_ballot got busy=%b rv=%b want 0 0", bus.o_busy, bus.o_result_valid);
        end
    endtask

    task automatic test_full_pass();
        int cyc;
        res_t exp, obs;
        do_start(3'd4, 3'd4);
        n_tests++;
        if (bus.o_busy !== 1'b1 || bus.o_result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy got busy=%b rv=%b want 1 0", bus.o_busy, bus.o_result_valid);
        end
        ballot(7'b1111111, 7'b0011111, 1'b0);
        m_expect(3'd4, 3'd4);
        wait_done(cyc);
        n_tests++;
        if (cyc !== 7) begin
            n_fail++;
            $display("FAIL auto_close_latency got %0d want 7", cyc);
        end
        exp = sb.pop_front();
        obs = get_obs();
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL full_pass got yes/turn/res=%b want %b", obs, exp);
        end
        step();
        step();
        n_tests++;
        if (bus.o_result_valid !== 1'b1 || get_obs() !== exp) begin
            n_fail++;
            $display("FAIL result_hold got rv=%b %b want 1 %b", bus.o_result_valid, get_obs(), exp);
        end
    endtask

    task automatic test_full_fail();
        int cyc;
        res_t exp, obs;
        do_start(3'd4, 3'd4);
        n_tests++;
        if (bus.o_result_valid !== 1'b0 || bus.o_result !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clears got rv=%b res=%b want 0 0", bus.o_result_valid, bus.o_result);
        end
        ballot(7'b1111111, 7'b0000001, 1'b0);
        m_expect(3'd4, 3'd4);
        wait_done(cyc);
        exp = sb.pop_front();
        obs = get_obs();
        n_tests++;
        if (cyc >= 64 || obs !== exp) begin
            n_fail++;
            $display("FAIL full_fail got yes/turn/res=%b cyc=%0d want %b", obs, cyc, exp);
        end
    endtask

    task automatic test_duplicate();
        int cyc;
        res_t exp, obs;
        do_start(3'd4, 3'd4);
        ballot(7'b0000001, 7'b0000001, 1'b0);
        ballot(7'b0000001, 7'b0000000, 1'b0);
        ballot(7'b0001110, 7'b0001110, 1'b0);
        m_expect(3'd4, 3'd4);
        do_close();
        wait_done(cyc);
        exp = sb.pop_front();
        obs = get_obs();
        n_tests++;
        if (cyc !== 7 || obs !== exp) begin
            n_fail++;
            $display("FAIL duplicate got yes/turn/res=%b cyc=%0d want %b cyc=7", obs, cyc, exp);
        end
    endtask

    task automatic test_quorum_fail();
        int cyc;
        res_t exp, obs;
        do_start(3'd3, 3'd4);
        ballot(7'b0000111, 7'b0000111, 1'b0);
        m_expect(3'd3, 3'd4);
        do_close();
        wait_done(cyc);
        exp = sb.pop_front();
        obs = get_obs();
        n_tests++;
        if (cyc >= 64 || obs !== exp) begin
            n_fail++;
            $display("FAIL quorum_fail got yes/turn/res=%b want %b", obs, exp);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        res_t exp, obs;
        do_start(3'd1, 3'd2);
        ballot(7'b0100000, 7'b0100000, 1'b0);
        ballot(7'b1000000, 7'b0000000, 1'b0);
        m_expect(3'd1, 3'd2);
        wait_done(cyc);
        n_tests++;
        if (cyc !== 21) begin
            n_fail++;
            $display("FAIL timeout_latency got %0d want 21", cyc);
        end
        exp = sb.pop_front();
        obs = get_obs();
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL timeout_counts got yes/turn/res=%b want %b", obs, exp);
        end
    endtask

    task automatic test_ballot_with_close();
        int cyc;
        res_t exp, obs;
        do_start(3'd3, 3'd3);
        ballot(7'b0000011, 7'b0000011, 1'b0);
        bus.i_start = 1'b1;
        ballot(7'b0000100, 7'b0000100, 1'b1);
        bus.i_start = 1'b0;
        m_expect(3'd3, 3'd3);
        wait_done(cyc);
        exp = sb.pop_front();
        obs = get_obs();
        n_tests++;
        if (cyc !== 7 || obs !== exp) begin
            n_fail++;
            $display("FAIL ballot_with_close got yes/turn/res=%b cyc=%0d want %b cyc=7", obs, cyc, exp);
        end
    endtask

    task automatic test_zero_ballots();
        int cyc;
        res_t exp, obs;
        do_start(3'd0, 3'd0);
        m_expect(3'd0, 3'd0);
        do_close();
        wait_done(cyc);
        exp = sb.pop_front();
        obs = get_obs();
        n_tests++;
        if (cyc >= 64 || obs !== exp) begin
            n_fail++;
            $display("FAIL zero_ballots got yes/turn/res=%b want %b", obs, exp);
        end
        do_start(3'd0, 3'd2);
        ballot(7'b0110000, 7'b0000000, 1'b1);
        m_expect(3'd0, 3'd2);
        wait_done(cyc);
        exp = sb.pop_front();
        obs = get_obs();
        n_tests++;
        if (cyc >= 64 || obs !== exp) begin
            n_fail++;
            $display("FAIL threshold_zero got yes/turn/res=%b want %b", obs, exp);
        end
    endtask

    task automatic test_reset_mid_tally();
        int cyc;
        logic [9:0] o;
        res_t exp, obs;
        do_start(3'd1, 3'd1);
        ballot(7'b1111111, 7'b1111111, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        o = {bus.o_busy, bus.o_result_valid, bus.o_result, bus.o_yes_count, bus.o_turnout};
        n_tests++;
        if (o !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_tally got %b want 0", o);
        end
        step();
        rst = 1'b0;
        step();
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_to_idle got busy=%b rv=%b want 0 0", bus.o_busy, bus.o_result_valid);
        end
        do_start(3'd1, 3'd1);
        ballot(7'b0000010, 7'b0000000, 1'b1);
        m_expect(3'd1, 3'd1);
        wait_done(cyc);
        exp = sb.pop_front();
        obs = get_obs();
        n_tests++;
        if (cyc >= 64 || obs !== exp) begin
            n_fail++;
            $display("FAIL clean_after_reset got yes/turn/res=%b want %b", obs, exp);
        end
    endtask

    initial begin
        bus.i_start        = 1'b0;
        bus.i_threshold    = '0;
        bus.i_quorum       = '0;
        bus.i_ballot_valid = 1'b0;
        bus.i_ballot_mask  = '0;
        bus.i_ballot_vote  = '0;
        bus.i_close        = 1'b0;
        m_voted = '0;
        m_votes = '0;
        test_reset();
        test_full_pass();
        test_full_fail();
        test_duplicate();
        test_quorum_fail();
        test_timeout();
        test_ballot_with_close();
        test_zero_ballots();
        test_reset_mid_tally();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/election_session.md
Name: election_session

Overview:
- Parametrised, sequential successor to the combinational 7-voter majority block.
- Runs a ballot session per request:
  - Opens on start.
  - Collects ballots from N voters over many cycles; first vote per voter wins.
  - Closes on command, timeout, or full turnout.
  - Tallies serially, one voter per cycle.
  - Reports pass/fail against a runtime threshold and quorum.
- Sits between voter-input logic and the decision consumer; the result is held until the next session starts.

Parameters:
- N_VOTERS, 7, number of voters (≥1).
- CNT_W, $clog2(N_VOTERS+1), width of all counts.
- TIMEOUT, 0, COLLECT cycles before auto-close; 0 disables the timeout.
- TO_W, 16, width of the timeout counter (TIMEOUT < 2^TO_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  open a new session; honoured in IDLE or DONE only.
- threshold  input  CNT_W  yes votes required; latched on accepted start.
- quorum  input  CNT_W  minimum turnout; latched on accepted start.
- ballot_valid  input  1  ballot strobe; honoured in COLLECT only.
- ballot_mask  input  N_VOTERS  voters casting this cycle.
- ballot_vote  input  N_VOTERS  vote per voter (1 = yes); meaningful where mask=1.
- close  input  1  end collection; honoured in COLLECT only.
- busy  output  1  high in COLLECT and TALLY.
- result_valid  output  1  high in DONE.
- result  output  1  1 iff yes_count ≥ threshold_l and turnout ≥ quorum_l.
- yes_count  output  CNT_W  final yes total; valid with result_valid.
- turnout  output  CNT_W  final count of voters that voted; valid with result_valid.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - voted, votes, counters, latched threshold/quorum, index, timer all 0.
  - All outputs 0.
  - Reset takes effect mid-session in any state; no partial result survives.
- States: IDLE, COLLECT, TALLY, DONE.
- IDLE/DONE with start=1 at an edge:
  - Latch threshold and quorum.
  - Clear voted, votes, yes_count, turnout and timer.
  - result_valid=0 and result=0 from that edge.
  - Next state COLLECT.
- COLLECT:
  - With ballot_valid=1, each bit i where mask[i]=1 and voted[i]=0 sets voted[i]=1 and votes[i]=vote[i].
  - Already-voted bits are ignored: the first vote stands.
  - Timer increments every COLLECT cycle.
  - Exit to TALLY at the edge where any of these holds:
    - close=1.
    - TIMEOUT≠0 and timer==TIMEOUT-1.
    - voted becomes all-ones, including via that edge's ballot.
  - A ballot in the same cycle as close or timeout is recorded before closing.
  - start in COLLECT or TALLY is ignored.
- TALLY:
  - Index 0..N_VOTERS-1, one voter per cycle.
  - turnout += voted[idx].
  - yes_count += voted[idx] & votes[idx].
  - Exactly N_VOTERS cycles in TALLY, then DONE.
  - ballot_valid and close are ignored.
- DONE:
  - result_valid=1; result, yes_count and turnout are registered and stable until the next accepted start or reset.
- Latency: close sampled at edge k → TALLY from k → result_valid=1 after edge k+N_VOTERS.
- Width and boundary rules:
  - Counts never exceed N_VOTERS, so CNT_W never overflows.
  - threshold=0 means pass on quorum alone.
  - threshold > N_VOTERS always fails.
  - Closing with zero ballots gives turnout=0 and yes_count=0, then the normal compare (quorum=0 and threshold=0 gives result=1).
- busy=1 exactly in COLLECT and TALLY.

Decomposition:
- Shared package election_pkg:
  - State enum (IDLE, COLLECT, TALLY, DONE).
  - Default N_VOTERS.
  - CNT_W helper function.
- One sub-module, election_ballot_box:
  - Holds the voted and votes registers with first-vote-wins update and the all-voted flag.
  - The FSM, timer and serial tally stay in election_session.

Test Plan (N_VOTERS=7, threshold=4, quorum=4 unless stated):
- Reset, then start; one ballot mask=7'b1111111 vote=7'b0011111 → auto-close; 7 cycles later result_valid=1, yes_count=5, turnout=7, result=1.
- Same flow with vote=7'b0000001 → yes_count=1, turnout=7, result=0.
- Duplicate vote:
  - Stimulus: voter0 votes 1; next cycle mask=7'b0000001 vote=0; voters 1-3 yes; close.
  - Response: yes_count=4, turnout=4, result=1.
- Quorum fail:
  - Stimulus: threshold=3, quorum=4; voters 0-2 yes; close.
  - Response: yes_count=3, turnout=3, result=0.
- Timeout and simultaneous events:
  - Stimulus: TIMEOUT=16; 2 ballots; no close.
  - Response: TALLY entered at COLLECT cycle 16.
  - Stimulus: a ballot plus close in the same cycle.
  - Response: the ballot is counted.
- rst pulsed mid-TALLY → all outputs 0 immediately, state IDLE; a subsequent start runs a clean session with counts from zero.
